instr_issue: RTL

Consumer end of the 8-entry instruction queue in the Tomasulo core.
- Pops one 16-bit instruction at a time through the queue's read handshake (empty flag, read strobe, registered instruction output).
- Decodes the instruction into op/register fields and routes it to the ADD, MUL or MEM reservation-station group.
- Holds the instruction until the target group has a free entry, then issues a one-cycle transfer.

---
 rtl/tomasulo_pkg.sv | 64 ++++++
 rtl/instr_decode.sv | 25 ++
 rtl/instr_issue.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: shared definitions for the Tomasulo front end.
// Holds opcode and class encodings, instruction field positions, the
// issue FSM state encoding and small opcode helper functions.
package tomasulo_pkg;

  localparam int INSTR_W = 16;

  // Opcodes, instruction bits [15:13]; 3'b110 and 3'b111 are invalid
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_LD  = 3'b100;
  localparam logic [2:0] OP_ST  = 3'b101;

  // Reservation-station group selected by the opcode
  localparam logic [1:0] CLS_ADD = 2'b00;
  localparam logic [1:0] CLS_MUL = 2'b01;
  localparam logic [1:0] CLS_MEM = 2'b10;

  // Field bit positions
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 13;
  localparam int RD_HI  = 12;
  localparam int RD_LO  = 10;
  localparam int RS_HI  = 9;
  localparam int RS_LO  = 7;
  localparam int RT_HI  = 6;
  localparam int RT_LO  = 4;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 0;

  // Issue FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_POP  = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;
  localparam logic [1:0] ST_DISP = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    POP  = ST_POP,
    CAPT = ST_CAPT,
    DISP = ST_DISP
  } issue_state_e;

  // True for the six defined opcodes
  function automatic logic op_valid(input logic [2:0] op);
    return (op <= OP_ST);
  endfunction

  // Map an opcode to its station group; invalid opcodes fall into MEM
  // but are never issued because op_valid rejects them first.
  function automatic logic [1:0] op_class(input logic [2:0] op);
    logic [1:0] cls;
    cls = CLS_MEM;
    case (op)
      OP_ADD, OP_SUB: cls = CLS_ADD;
      OP_MUL, OP_DIV: cls = CLS_MUL;
      default:        cls = CLS_MEM;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// instr_decode: purely combinational split of a 16-bit instruction into
// opcode, station class, register fields, immediate and a valid flag.
// Shared by the issue stage and the commit logic.
module instr_decode
  import tomasulo_pkg::*;
(
  input  logic [15:0] instr,
  output logic [2:0]  op,
  output logic [1:0]  cls,
  output logic [2:0]  rd,
  output logic [2:0]  rs,
  output logic [2:0]  rt,
  output logic [3:0]  imm,
  output logic        valid
);

  assign op    = instr[OP_HI:OP_LO];
  assign rd    = instr[RD_HI:RD_LO];
  assign rs    = instr[RS_HI:RS_LO];
  assign rt    = instr[RT_HI:RT_LO];
  assign imm   = instr[IMM_HI:IMM_LO];
  assign cls   = op_class(instr[OP_HI:OP_LO]);
  assign valid = op_valid(instr[OP_HI:OP_LO]);

endmodule

// File: rtl/instr_issue.sv
// instr_issue: consumer end of the instruction queue. Pops one
// instruction, decodes it, waits for a free entry in the target
// reservation-station group and issues a one-cycle transfer.
// Optional statistics counters are built when ISSUE_STATS_EN is defined.
//
// Handshakes:
//   queue side: q_rd is a one-cycle read strobe raised only in POP; the
//   queue ignores it when q_push is high that cycle, which is recorded in
//   lost_pop and makes CAPT abandon the capture and retry from IDLE.
//   q_instr is valid the cycle after an accepted pop.
//   station side: iss_valid is asserted in DISP whenever the target
//   group's free flag is high; every cycle with iss_valid=1 is a completed
//   transfer (the free flag acts as ready). Fields are held stable for the
//   whole DISP dwell.
module instr_issue
  import tomasulo_pkg::*;
`ifdef ISSUE_STATS_EN
  #(parameter int CNT_W = 16)
`endif
(
  input  logic             CLK,
  input  logic             CLR,
  input  logic             q_empty,
  input  logic             q_push,
  output logic             q_rd,
  input  logic [15:0]      q_instr,
  input  logic             flush,
  input  logic             rs_add_free,
  input  logic             rs_mul_free,
  input  logic             rs_mem_free,
  output logic             iss_valid,
  output logic [1:0]       iss_class,
  output logic [2:0]       iss_op,
  output logic [2:0]       iss_rd,
  output logic [2:0]       iss_rs,
  output logic [2:0]       iss_rt,
  output logic [3:0]       iss_imm,
  output logic             bad_op,
  output logic             busy,
  output logic [1:0]       dbg_state
`ifdef ISSUE_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt_issued,
  output logic [CNT_W-1:0] cnt_dropped,
  output logic [CNT_W-1:0] cnt_stall
`endif
);

  issue_state_e state;
  logic [15:0]  instr_r;
  logic         lost_pop;

  logic [2:0]   dec_op;
  logic [1:0]   dec_cls;
  logic [2:0]   dec_rd;
  logic [2:0]   dec_rs;
  logic [2:0]   dec_rt;
  logic [3:0]   dec_imm;
  logic         dec_valid;
  logic         tgt_free;

  // Issue fields always come from the held instruction register
  instr_decode u_decode (
    .instr (instr_r),
    .op    (dec_op),
    .cls   (dec_cls),
    .rd    (dec_rd),
    .rs    (dec_rs),
    .rt    (dec_rt),
    .imm   (dec_imm),
    .valid (dec_valid)
  );

  // Select the free flag of the held instruction's group only
  always_comb begin
    tgt_free = 1'b0;
    case (dec_cls)
      CLS_ADD: tgt_free = rs_add_free;
      CLS_MUL: tgt_free = rs_mul_free;
      CLS_MEM: tgt_free = rs_mem_free;
      default: tgt_free = 1'b0;
    endcase
  end

  assign q_rd      = (state == POP) && !flush;
  assign iss_valid = (state == DISP) && tgt_free && dec_valid && !flush;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  assign iss_class = dec_cls;
  assign iss_op    = dec_op;
  assign iss_rd    = dec_rd;
  assign iss_rs    = dec_rs;
  assign iss_rt    = dec_rt;
  assign iss_imm   = dec_imm;

  // Issue FSM: pop, capture/validate, dispatch; flush overrides all states
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state    <= IDLE;
      instr_r  <= '0;
      lost_pop <= 1'b0;
      bad_op   <= 1'b0;
    end else begin
      bad_op <= 1'b0;
      if (flush) begin
        state   <= IDLE;
        instr_r <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!q_empty) state <= POP;
          end
          POP: begin
            lost_pop <= q_push;
            state    <= CAPT;
          end
          CAPT: begin
            if (lost_pop) begin
              state <= IDLE;
            end else if (op_valid(q_instr[OP_HI:OP_LO])) begin
              instr_r <= q_instr;
              state   <= DISP;
            end else begin
              bad_op <= 1'b1;
              state  <= IDLE;
            end
          end
          DISP: begin
            if (iss_valid) state <= q_empty ? IDLE : POP;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef ISSUE_STATS_EN
  // Wrapping event counters for issue, drop and stall activity
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      cnt_issued  <= '0;
      cnt_dropped <= '0;
      cnt_stall   <= '0;
    end else begin
      if (iss_valid)
        cnt_issued <= cnt_issued + 1'b1;
      if (bad_op || (flush && ((state == CAPT) || (state == DISP))))
        cnt_dropped <= cnt_dropped + 1'b1;
      if ((state == DISP) && !iss_valid)
        cnt_stall <= cnt_stall + 1'b1;
    end
  end
`endif

endmodule
